// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state type, constants and parity helper for param_sram
package sram_pkg;

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} sram_state_e;

   localparam int MAX_READ_LAT = 2;
   localparam int BYTE_W       = 8;

   // Even parity: the stored bit makes the total count of ones across byte+bit even.
   function automatic logic even_parity(input logic [BYTE_W-1:0] data_byte);
      return ^data_byte;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - READ_LAT-deep data/valid/parity delay line with synchronous clear
module sram_rd_pipe
   import sram_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_perr,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr
);

   localparam int LAT = (READ_LAT >= MAX_READ_LAT) ? MAX_READ_LAT : 1;

   logic              s0_valid;
   logic              s0_perr;
   logic [DATA_W-1:0] s0_data;

   // Data registers only load on a valid beat so the output holds between reads.
   always_ff @(posedge clk) begin
      if (clr) begin
         s0_valid <= 1'b0;
         s0_perr  <= 1'b0;
         s0_data  <= '0;
      end else begin
         s0_valid <= in_valid;
         s0_perr  <= in_valid & in_perr;
         if (in_valid) s0_data <= in_data;
      end
   end

   generate
      if (LAT == 2) begin : g_lat2
         logic              s1_valid;
         logic              s1_perr;
         logic [DATA_W-1:0] s1_data;

         always_ff @(posedge clk) begin
            if (clr) begin
               s1_valid <= 1'b0;
               s1_perr  <= 1'b0;
               s1_data  <= '0;
            end else begin
               s1_valid <= s0_valid;
               s1_perr  <= s0_perr;
               if (s0_valid) s1_data <= s0_data;
            end
         end

         assign out_valid = s1_valid;
         assign out_data  = s1_data;
         assign out_perr  = s1_perr;
      end else begin : g_lat1
         assign out_valid = s0_valid;
         assign out_data  = s0_data;
         assign out_perr  = s0_perr;
      end
   endgenerate

endmodule

// File: rtl/param_sram.sv
// rtl/param_sram.sv - parametrised byte-masked SRAM with clear sweep; optional SRAM_PARITY_EN
module param_sram
   import sram_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 96,
   parameter int                ADDR_W     = 7,
   parameter int                READ_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic                sram_clk,
   input  logic                sram_ares,
   input  logic                wr_enable,
   input  logic                rd_enable,
   input  logic [ADDR_W-1:0]   ram_index,
   input  logic [DATA_W/8-1:0] byte_en,
   input  logic [DATA_W-1:0]   sram_data_in,
   output logic [DATA_W-1:0]   sram_data_out,
   output logic                rd_valid,
   output logic                init_busy,
   output logic                req_err,
   output logic                parity_err
);

   localparam int                NB       = DATA_W / BYTE_W;
   localparam logic [0:0]        S_INIT   = ST_INIT;
   localparam logic [0:0]        S_READY  = ST_READY;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              ready;
   logic              in_range;
   logic              wr_ok;
   logic              rd_ok;
   logic [DATA_W-1:0] rd_word;
   logic              rd_perr;

   assign ready     = (state == S_READY);
   assign init_busy = ~ready;
   assign in_range  = 32'(ram_index) < 32'(DEPTH);
   assign wr_ok     = wr_enable & ready & in_range;
   assign rd_ok     = rd_enable & ready & in_range;
   assign rd_word   = mem[ram_index];

   always_ff @(posedge sram_clk) begin
      if (sram_ares) begin
         state   <= S_INIT;
         clr_cnt <= '0;
      end else if (state == S_INIT) begin
         if (clr_cnt == LAST_IDX) state <= S_READY;
         else                     clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // Non-blocking array update gives read-first behaviour on a same-index collision.
   always_ff @(posedge sram_clk) begin
      if (!sram_ares) begin
         if (!ready) begin
            mem[clr_cnt] <= INIT_VALUE;
         end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
               if (byte_en[b]) mem[ram_index][b*BYTE_W +: BYTE_W] <= sram_data_in[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Rejected read and write in one cycle still yield a single pulse.
   always_ff @(posedge sram_clk) begin
      if (sram_ares) req_err <= 1'b0;
      else           req_err <= (wr_enable | rd_enable) & ~(ready & in_range);
   end

`ifdef SRAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];

   always_ff @(posedge sram_clk) begin
      if (!sram_ares) begin
         if (!ready) begin
            for (int b = 0; b < NB; b++) par_mem[clr_cnt][b] <= even_parity(INIT_VALUE[b*BYTE_W +: BYTE_W]);
         end else if (wr_ok) begin
            for (int b = 0; b < NB; b++) begin
               if (byte_en[b]) par_mem[ram_index][b] <= even_parity(sram_data_in[b*BYTE_W +: BYTE_W]);
            end
         end
      end
   end

   always_comb begin
      rd_perr = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (even_parity(rd_word[b*BYTE_W +: BYTE_W]) != par_mem[ram_index][b]) rd_perr = 1'b1;
      end
   end
`else
   assign rd_perr = 1'b0;
`endif

   sram_rd_pipe #(
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT)
   ) u_rd_pipe (
      .clk       (sram_clk),
      .clr       (sram_ares),
      .in_valid  (rd_ok),
      .in_data   (rd_word),
      .in_perr   (rd_perr),
      .out_valid (rd_valid),
      .out_data  (sram_data_out),
      .out_perr  (parity_err)
   );

endmodule

// File: tb/tb_param_sram.sv
// tb/tb_param_sram.sv - bench for param_sram at READ_LAT 1 and 2; SRAM_PARITY_EN adds fault injection
module tb_param_sram;

   localparam int DEPTH = 96;

   logic        clk = 1'b0;
   logic        ares;
   logic        wr, rd;
   logic [6:0]  idx;
   logic [3:0]  be;
   logic [31:0] din;

   logic [31:0] dout [2];
   logic [1:0]  rv, busy, err, perr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   param_sram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(7), .READ_LAT(1), .INIT_VALUE(32'hA5A5A5A5)) u_a (
      .sram_clk(clk), .sram_ares(ares), .wr_enable(wr), .rd_enable(rd), .ram_index(idx),
      .byte_en(be), .sram_data_in(din), .sram_data_out(dout[0]), .rd_valid(rv[0]),
      .init_busy(busy[0]), .req_err(err[0]), .parity_err(perr[0]));

   param_sram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(7), .READ_LAT(2), .INIT_VALUE(32'h00000000)) u_b (
      .sram_clk(clk), .sram_ares(ares), .wr_enable(wr), .rd_enable(rd), .ram_index(idx),
      .byte_en(be), .sram_data_in(din), .sram_data_out(dout[1]), .rd_valid(rv[1]),
      .init_busy(busy[1]), .req_err(err[1]), .parity_err(perr[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: per-instance word array, sweep countdown, and a slot ring of due responses.
   logic [31:0] mm   [2][DEPTH];
   logic        bad  [2][DEPTH];
   logic        sv   [2][4];
   logic [31:0] sd   [2][4];
   logic        sp   [2][4];
   int          init_left [2];
   logic [31:0] e_dout [2];
   logic        e_rv [2], e_err [2], e_perr [2], e_busy [2];
   logic        live = 1'b0;
   logic        ok_m;
   int          cyc = 0;
   int          s_m;

   function automatic logic [31:0] initv(input int k);
      return (k == 0) ? 32'hA5A5A5A5 : 32'h00000000;
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (ares) begin
            init_left[k] = DEPTH;
            for (int s = 0; s < 4; s++) begin sv[k][s] = 1'b0; sp[k][s] = 1'b0; end
            e_dout[k] = '0; e_rv[k] = 1'b0; e_err[k] = 1'b0; e_perr[k] = 1'b0;
         end else begin
            ok_m     = (init_left[k] == 0) && (int'(idx) < DEPTH);
            e_err[k] = (wr || rd) && !ok_m;
            if (rd && ok_m) begin
               s_m = (cyc + k) % 4;
               sv[k][s_m] = 1'b1;
               sd[k][s_m] = mm[k][idx];
               sp[k][s_m] = bad[k][idx];
            end
            if (wr && ok_m) begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) begin
                     mm[k][idx][8*b +: 8] = din[8*b +: 8];
                     if (b == 2) bad[k][idx] = 1'b0;
                  end
               end
            end
            if (init_left[k] > 0) begin
               mm[k][DEPTH - init_left[k]]  = initv(k);
               bad[k][DEPTH - init_left[k]] = 1'b0;
               init_left[k]--;
            end
            s_m       = cyc % 4;
            e_rv[k]   = sv[k][s_m];
            e_perr[k] = sp[k][s_m];
            if (sv[k][s_m]) e_dout[k] = sd[k][s_m];
            sv[k][s_m] = 1'b0;
            sp[k][s_m] = 1'b0;
         end
         e_busy[k] = init_left[k] > 0;
      end
      if (ares) live = 1'b1;
   end

   always @(negedge clk) begin
      if (live) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), busy[k], e_busy[k]);
            chk($sformatf("rd_valid%0d", k), rv[k], e_rv[k]);
            chk($sformatf("req_err%0d", k), err[k], e_err[k]);
            chk($sformatf("parity_err%0d", k), perr[k], e_perr[k]);
            chk($sformatf("dout%0d", k), dout[k], e_dout[k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic w, input logic r, input logic [6:0] i, input logic [3:0] m, input logic [31:0] d);
      wr = w; rd = r; idx = i; be = m; din = d;
      step();
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int inject_at);
      int n;
      n = 0;
      while (busy[0] && n < 300) begin
         if (n == inject_at) op(1'b1, 1'b0, 7'd0, 4'hF, 32'hFFFFFFFF);
         else                step();
         n++;
      end
      chk(name, n, DEPTH);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ares = 1'b1; wr = 1'b0; rd = 1'b0; idx = '0; be = '0; din = '0;
      step();
      chk("rst_dout", dout[0], 32'h0);
      chk("rst_busy", busy[0], 1'b1);
      ares = 1'b0;
      wait_ready("init_len", 5);

      // Clear sweep contents; index 0 was the target of the rejected write during INIT.
      op(1'b0, 1'b1, 7'd0, 4'h0, 32'h0);
      chk("sweep_idx0", dout[0], 32'hA5A5A5A5);
      chk("sweep_idx0_valid", rv[0], 1'b1);
      op(1'b0, 1'b1, 7'd47, 4'h0, 32'h0);
      chk("sweep_idx47", dout[0], 32'hA5A5A5A5);
      op(1'b0, 1'b1, 7'd95, 4'h0, 32'h0);
      chk("sweep_idx95", dout[0], 32'hA5A5A5A5);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      chk("b_idx95_valid", rv[1], 1'b1);

      // Byte mask
      op(1'b1, 1'b0, 7'd5, 4'b0101, 32'h11223344);
      op(1'b0, 1'b1, 7'd5, 4'h0, 32'h0);
      chk("mask_a", dout[0], 32'hA522A544);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      chk("mask_b", dout[1], 32'h00220044);

      // Rejections at and beyond DEPTH
      op(1'b0, 1'b1, 7'd100, 4'h0, 32'h0);
      chk("oor_err", err[0], 1'b1);
      chk("oor_novalid", rv[0], 1'b0);
      op(1'b1, 1'b1, 7'd96, 4'hF, 32'h12345678);
      op(1'b1, 1'b0, 7'd127, 4'hF, 32'h12345678);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      chk("err_clears", err[0], 1'b0);

      // Read-first collision
      op(1'b1, 1'b0, 7'd9, 4'hF, 32'hDEADBEEF);
      op(1'b1, 1'b1, 7'd9, 4'hF, 32'h00000000);
      chk("collide_old", dout[0], 32'hDEADBEEF);
      op(1'b0, 1'b1, 7'd9, 4'h0, 32'h0);
      chk("collide_new", dout[0], 32'h00000000);
      chk("collide_old_b", dout[1], 32'hDEADBEEF);

      // byte_en=0 write is a silent no-op
      op(1'b1, 1'b0, 7'd5, 4'h0, 32'hFFFFFFFF);
      chk("noop_err", err[0], 1'b0);
      op(1'b0, 1'b1, 7'd5, 4'h0, 32'h0);
      chk("noop_keep", dout[0], 32'hA522A544);

      // Directed write table, then back-to-back read-back plus top-index boundary
      for (int i = 0; i < 12; i++)
         op(1'b1, 1'b0, 7'(i * 8 + 1), 4'(i + 3), 32'h0F1E2D3C * (i + 1));
      op(1'b1, 1'b0, 7'd95, 4'hF, 32'hCAFEF00D);
      for (int i = 0; i < 12; i++)
         op(1'b0, 1'b1, 7'(i * 8 + 1), 4'h0, 32'h0);
      op(1'b0, 1'b1, 7'd95, 4'h0, 32'h0);
      chk("top_idx", dout[0], 32'hCAFEF00D);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);

      // Reset at sweep word 40 restarts the sweep
      ares = 1'b1; step(); ares = 1'b0;
      for (int i = 0; i < 40; i++) step();
      ares = 1'b1; step(); ares = 1'b0;
      wait_ready("init_len_restart", -1);

      // Reset with reads in flight drops them
      op(1'b0, 1'b1, 7'd3, 4'h0, 32'h0);
      ares = 1'b1;
      step();
      chk("flush_a", rv[0], 1'b0);
      chk("flush_b", rv[1], 1'b0);
      ares = 1'b0;
      wait_ready("init_len_flush", -1);

`ifdef SRAM_PARITY_EN
      u_a.par_mem[3][2] = ~u_a.par_mem[3][2];
      u_b.par_mem[3][2] = ~u_b.par_mem[3][2];
      bad[0][3] = 1'b1;
      bad[1][3] = 1'b1;
      op(1'b0, 1'b1, 7'd3, 4'h0, 32'h0);
      chk("perr_a", perr[0], 1'b1);
      chk("perr_a_valid", rv[0], 1'b1);
      op(1'b0, 1'b1, 7'd4, 4'h0, 32'h0);
      chk("perr_b", perr[1], 1'b1);
      chk("perr_a_clean", perr[0], 1'b0);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      chk("perr_b_clean", perr[1], 1'b0);
`else
      op(1'b0, 1'b1, 7'd3, 4'h0, 32'h0);
      chk("perr_off", perr[0], 1'b0);
`endif
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);
      op(1'b0, 1'b0, 7'd0, 4'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
